// File: rtl/kmc_npr_pkg.sv
// Shared definitions for the multi-channel KMC NPR arbiter: NPRC bit layout,
// arbiter FSM states and the round-robin search helper.
package kmc_npr_pkg;

  localparam int BIT_BYTEXFER = 7;
  localparam int BIT_NPRO     = 4;
  localparam int BIT_BAEI_HI  = 3;
  localparam int BIT_BAEI_LO  = 2;
  localparam int BIT_NLXFER   = 1;
  localparam int BIT_NPRRQ    = 0;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } npr_state_t;

  // First pending index strictly after 'last' (wrapping, 'last' itself checked
  // last). Passing last = nch-1 turns this into lowest-index-wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] pend,
                                         input logic [2:0] last,
                                         input int         nch);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (k <= nch) begin
        idx = 3'((int'(last) + k) % nch);
        if (pend[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/kmc_npr_chreg.sv
// One NPR channel control register: stored NPRC fields plus the PEND/ACTIVE
// pair that feeds the arbiter and the BUSY readback bit.
module kmc_npr_chreg
  import kmc_npr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       ld,
  input  logic [7:0] alu,
  input  logic       grant,
  input  logic       finish,
  output logic       pend,
  output logic [7:0] nprc,
  output logic       byte_xfer,
  output logic       npro,
  output logic [1:0] bae
);

  logic       byte_reg;
  logic       npro_reg;
  logic [1:0] bae_reg;
  logic       nlx_reg;
  logic       pend_reg;
  logic       active_reg;
  logic       ld_ok;
  logic       unused_alu;

  assign ld_ok      = ld && !active_reg;
  assign unused_alu = ^alu[6:5];

  always_ff @(posedge clk) begin
    if (!rst || init) begin
      byte_reg   <= 1'b0;
      npro_reg   <= 1'b0;
      bae_reg    <= 2'b00;
      nlx_reg    <= 1'b0;
      pend_reg   <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      if (ld_ok) begin
        byte_reg <= alu[BIT_BYTEXFER];
        npro_reg <= alu[BIT_NPRO];
        bae_reg  <= alu[BIT_BAEI_HI:BIT_BAEI_LO];
        nlx_reg  <= alu[BIT_NLXFER];
      end
      // A grant consumes the request even if a reload lands on the same edge.
      if (grant) begin
        pend_reg   <= 1'b0;
        active_reg <= 1'b1;
      end else if (ld_ok) begin
        pend_reg <= alu[BIT_NPRRQ];
      end
      if (finish) active_reg <= 1'b0;
    end
  end

  assign pend      = pend_reg;
  assign byte_xfer = byte_reg;
  assign npro      = npro_reg;
  assign bae       = bae_reg;
  assign nprc      = {byte_reg, 2'b00, npro_reg, bae_reg, nlx_reg, pend_reg | active_reg};

endmodule

// File: rtl/kmc_npr_arb.sv
// Multi-channel NPR arbiter: NCH channel registers share one device DMA
// request/acknowledge pair, with an NXM timeout per transfer.
module kmc_npr_arb
  import kmc_npr_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int NXMCYC = 100,
  parameter  int RRARB  = 1,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kmcINIT,
  input  logic [NCH-1:0]   chLD,
  input  logic [8*NCH-1:0] chALU,
  input  logic             devACKI,
  output logic             devREQO,
  output logic [CHW-1:0]   devCH,
  output logic             devNPRO,
  output logic [1:0]       devBAE,
  output logic             devBYTE,
  output logic [8*NCH-1:0] chNPRC,
  output logic [NCH-1:0]   chDONE,
  output logic [NCH-1:0]   chNXM
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NXMCYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  npr_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CHW-1:0]   rr_ptr_reg;
  logic [CHW-1:0]   pick_idx;
  logic [NCH-1:0]   pend_vec;
  logic [NCH-1:0]   byte_vec;
  logic [NCH-1:0]   npro_vec;
  logic [1:0]       bae_arr [NCH];
  logic [NCH-1:0]   grant_vec;
  logic [NCH-1:0]   done_next;
  logic [NCH-1:0]   nxm_next;
  logic [NCH-1:0]   finish_vec;
  logic             req_next;
  logic             any_pend;
  logic [7:0]       pend8;
  logic [2:0]       last3;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    kmc_npr_chreg u_chreg (
      .clk       (clk),
      .rst       (rst),
      .init      (kmcINIT),
      .ld        (chLD[gi]),
      .alu       (chALU[8*gi +: 8]),
      .grant     (grant_vec[gi]),
      .finish    (finish_vec[gi]),
      .pend      (pend_vec[gi]),
      .nprc      (chNPRC[8*gi +: 8]),
      .byte_xfer (byte_vec[gi]),
      .npro      (npro_vec[gi]),
      .bae       (bae_arr[gi])
    );
  end

  assign any_pend = |pend_vec;
  assign pend8    = 8'(pend_vec);
  assign last3    = (RRARB != 0) ? 3'(rr_ptr_reg) : 3'(NCH - 1);
  assign pick_idx = CHW'(rr_pick(pend8, last3, NCH));

  always_ff @(posedge clk) begin
    if (!rst || kmcINIT) state_reg <= IDLE;
    else                 state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_pend) state_next = SETUP;
      SETUP:   state_next = REQ;
      REQ:     if (devACKI || cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ACK is tested before the counter so an ACK on the last cycle still wins.
  always_comb begin
    grant_vec = '0;
    done_next = '0;
    nxm_next  = '0;
    req_next  = 1'b0;
    case (state_reg)
      IDLE:  if (any_pend) grant_vec[pick_idx] = 1'b1;
      SETUP: req_next = 1'b1;
      REQ: begin
        if (devACKI)              done_next[devCH] = 1'b1;
        else if (cnt_reg == '0)   nxm_next[devCH]  = 1'b1;
        else                      req_next         = 1'b1;
      end
      default: ;
    endcase
  end

  assign finish_vec = done_next | nxm_next;

  always_ff @(posedge clk) begin
    if (!rst || kmcINIT) begin
      cnt_reg    <= '0;
      rr_ptr_reg <= '0;
      devREQO    <= 1'b0;
      devCH      <= '0;
      devNPRO    <= 1'b0;
      devBAE     <= 2'b00;
      devBYTE    <= 1'b0;
      chDONE     <= '0;
      chNXM      <= '0;
    end else begin
      devREQO <= req_next;
      chDONE  <= done_next;
      chNXM   <= nxm_next;
      if (state_reg == IDLE && any_pend) begin
        devCH   <= pick_idx;
        devNPRO <= npro_vec[pick_idx];
        devBAE  <= bae_arr[pick_idx];
        devBYTE <= byte_vec[pick_idx];
      end
      if (state_reg == SETUP)
        cnt_reg <= CNT_LOAD;
      else if (state_reg == REQ && !devACKI && cnt_reg != '0)
        cnt_reg <= cnt_reg - CNT_ONE;
      if (state_reg == DONE) rr_ptr_reg <= devCH;
    end
  end

endmodule
